// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared execute-stage ALU.
// Each RUN cycle adds the (conditionally) shifted multiplicand into the accumulator.
module alu_mul_sequencer #(
  parameter int unsigned n = 64
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic [n-1:0] OpA,
  input  logic [n-1:0] OpB,
  output logic         Busy,
  output logic         Done,
  output logic [n-1:0] Product,
  output logic         ALUSel,
  output logic [3:0]   ALUCtrl,
  output logic [n-1:0] ALUBusA,
  output logic [n-1:0] ALUBusB,
  input  logic [n-1:0] ALUBusW
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0010;

  logic [1:0]   state, stateNext;
  logic [n-1:0] acc, accNext;
  logic [n-1:0] mcand, mcandNext;
  logic [n-1:0] mplier, mplierNext;
  logic [n-1:0] productNext;
  logic         runNext;
  logic         busyNext, doneNext, aluSelNext;
  logic [3:0]   aluCtrlNext;
  logic [n-1:0] busANext, busBNext;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    stateNext   = state;
    accNext     = acc;
    mcandNext   = mcand;
    mplierNext  = mplier;
    productNext = Product;

    case (state)
      IDLE: begin
        if (Start) begin
          accNext     = '0;
          mcandNext   = OpA;
          mplierNext  = OpB;
          productNext = '0;
          stateNext   = RUN;
        end
      end
      RUN: begin
        if (mplier != '0) begin
          accNext    = ALUBusW;
          mcandNext  = mcand << 1;
          mplierNext = mplier >> 1;
        end else begin
          productNext = acc;
          stateNext   = DONE;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // ALU drive is precomputed for the cycle being entered, so it lines up with acc.
    runNext     = (stateNext == RUN);
    busyNext    = (stateNext == RUN) || (stateNext == DONE);
    doneNext    = (stateNext == DONE);
    aluSelNext  = runNext;
    aluCtrlNext = runNext ? ALU_ADD : 4'b0000;
    busANext    = runNext ? accNext : '0;
    busBNext    = (runNext && mplierNext[0]) ? mcandNext : '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      Product <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      ALUSel  <= 1'b0;
      ALUCtrl <= 4'b0000;
      ALUBusA <= '0;
      ALUBusB <= '0;
    end else begin
      state   <= stateNext;
      acc     <= accNext;
      mcand   <= mcandNext;
      mplier  <= mplierNext;
      Product <= productNext;
      Busy    <= busyNext;
      Done    <= doneNext;
      ALUSel  <= aluSelNext;
      ALUCtrl <= aluCtrlNext;
      ALUBusA <= busANext;
      ALUBusB <= busBNext;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer with a behavioural ALU and an
// arithmetic reference model for product and latency.
module tb_alu_mul_sequencer;

  localparam int unsigned N = 64;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         Start;
  logic [N-1:0] OpA, OpB;
  logic         Busy, Done, ALUSel;
  logic [N-1:0] Product, ALUBusA, ALUBusB, ALUBusW;
  logic [3:0]   ALUCtrl;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer #(.n(N)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Product(Product), .ALUSel(ALUSel),
    .ALUCtrl(ALUCtrl), .ALUBusA(ALUBusA), .ALUBusB(ALUBusB), .ALUBusW(ALUBusW)
  );

  // Shared ALU: only ADD is exercised by the sequencer.
  assign ALUBusW = (ALUCtrl == 4'b0010) ? ALUBusA + ALUBusB : '0;

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int expEdges(input logic [N-1:0] b);
    int m = -1;
    for (int i = 0; i < int'(N); i++) if (b[i]) m = i;
    return (m < 0) ? 2 : m + 3;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".busy"},    N'(Busy),    '0);
    check({tag, ".done"},    N'(Done),    '0);
    check({tag, ".alusel"},  N'(ALUSel),  '0);
    check({tag, ".aluctrl"}, N'(ALUCtrl), '0);
    check({tag, ".busa"},    ALUBusA,     '0);
    check({tag, ".busb"},    ALUBusB,     '0);
  endtask

  // One multiply; optionally pokes Start with other operands while busy.
  task automatic doMul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input bit poke);
    logic [N-1:0] expProd;
    int edges, selCycles;
    bit seen, ctrlBad;
    expProd = a * b;
    @(negedge CLK);
    OpA = a; OpB = b; Start = 1'b1;
    @(posedge CLK);
    edges = 1;
    #1 Start = 1'b0;
    OpA = {$urandom, $urandom}; OpB = {$urandom, $urandom};
    selCycles = 0; seen = 0; ctrlBad = 0;
    while (!seen && edges < 200) begin
      @(negedge CLK);
      if (Done) seen = 1;
      else begin
        if (ALUSel) selCycles++;
        if (ALUCtrl != 4'b0010 || !Busy) ctrlBad = 1;
        Start = poke && (edges == 3);
        @(posedge CLK);
        edges++;
        #1 Start = 1'b0;
      end
    end
    check({tag, ".seen_done"}, N'(seen), N'(1));
    check({tag, ".edges"},     N'(edges), N'(expEdges(b)));
    check({tag, ".runcycles"}, N'(selCycles), N'(expEdges(b) - 1));
    check({tag, ".ctrl_in_run"}, N'(ctrlBad), '0);
    check({tag, ".product"},   Product, expProd);
    check({tag, ".busy_done"}, N'(Busy), N'(1));
    check({tag, ".sel_done"},  N'(ALUSel), '0);
    @(negedge CLK);
    checkIdleOutputs({tag, ".idle"});
    check({tag, ".product_held"}, Product, expProd);
  endtask

  initial begin
    logic [N-1:0] a, b;
    Reset = 1'b1; Start = 1'b0; OpA = '0; OpB = '0;
    repeat (2) @(negedge CLK);
    checkIdleOutputs("reset");
    check("reset.product", Product, '0);
    Reset = 1'b0;

    doMul("t2", 64'd3, 64'd5, 0);

    // Reset while idle clears the held product.
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    checkIdleOutputs("t1");
    check("t1.product", Product, '0);
    @(negedge CLK);
    Reset = 1'b0;

    doMul("t3", 64'd123, 64'd0, 0);
    doMul("t4", 64'd3, 64'h8000_0000_0000_0000, 0);
    doMul("t5", '1, '1, 1);

    // Abort a long multiply during its tenth RUN cycle.
    @(negedge CLK);
    OpA = 64'd3; OpB = 64'h8000_0000_0000_0000; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    check("t6.sel_before", N'(ALUSel), N'(1));
    Reset = 1'b1;
    #1;
    checkIdleOutputs("t6");
    check("t6.product", Product, '0);
    @(negedge CLK);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("t6.no_done", N'(Done), '0);
    end
    doMul("t6b", 64'd7, 64'd6, 0);

    // Back-to-back random operations with varied multiplier widths.
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i == 3) a = '0;
      doMul($sformatf("rnd%0d", i), a, b, (i % 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
